// File: rtl/ahb_slave_mem.sv
// rtl/ahb_slave_mem.sv - AHB slave with word-addressed register-file memory, wait states and ERROR response
// Optional feature macro: AHB_SLV_BYTE_LANE_EN (legal byte/halfword transfers with lane-masked writes)
module ahb_slave_mem #(
  parameter int ADDR_W      = 4,
  parameter int WAIT_STATES = 1
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic [1:0]  hresp,
  output logic [31:0] hrdata
);

  localparam int         DEPTH     = 1 << ADDR_W;
  localparam logic [2:0] WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [2:0]        wait_cnt;
  logic [ADDR_W-1:0] cap_idx;
  logic              cap_write;
  logic [31:0]       mem [DEPTH];
  logic              can_accept;
  logic              accept;
  logic              addr_err;
  logic              do_write;

  // New address phases are only taken when the previous data phase is completing
  assign can_accept = (state == ST_IDLE) || (state == ST_DATA) || (state == ST_ERR2);
  assign accept     = can_accept & hsel & hready & htrans[1];
  assign do_write   = (state == ST_DATA) && cap_write;

  // Classify the address phase on the bus as legal or ERROR
  always_comb begin
    addr_err = 1'b0;
    if (haddr[31:ADDR_W+2] != '0)                  addr_err = 1'b1;
    if (hsize > 3'b010)                            addr_err = 1'b1;
    if (hsize == 3'b010 && haddr[1:0] != 2'b00)    addr_err = 1'b1;
    if (hsize == 3'b001 && haddr[0])               addr_err = 1'b1;
`ifndef AHB_SLV_BYTE_LANE_EN
    if (hsize != 3'b010)                           addr_err = 1'b1;
`endif
  end

  // Next-state and response outputs; an accept overrides the default return to idle
  always_comb begin
    state_next = ST_IDLE;
    hreadyout  = 1'b1;
    hresp      = 2'b00;
    case (state)
      ST_WAIT: begin
        hreadyout  = 1'b0;
        state_next = (wait_cnt == 3'd0) ? ST_DATA : ST_WAIT;
      end
      ST_ERR1: begin
        hreadyout  = 1'b0;
        hresp      = 2'b01;
        state_next = ST_ERR2;
      end
      ST_ERR2: hresp = 2'b01;
      default: ;
    endcase
    if (accept) begin
      if (addr_err)             state_next = ST_ERR1;
      else if (WAIT_STATES > 0) state_next = ST_WAIT;
      else                      state_next = ST_DATA;
    end
  end

  // State register, wait counter and captured address/control
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state     <= ST_IDLE;
      wait_cnt  <= 3'd0;
      cap_idx   <= '0;
      cap_write <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        wait_cnt  <= WAIT_LOAD;
        cap_idx   <= haddr[ADDR_W+1:2];
        cap_write <= hwrite;
      end else if (state == ST_WAIT && wait_cnt != 3'd0) begin
        wait_cnt <= wait_cnt - 3'd1;
      end
    end
  end

`ifdef AHB_SLV_BYTE_LANE_EN
  logic [2:0] cap_size;
  logic [1:0] cap_off;
  logic [3:0] lane_mask;

  // Remember transfer size and byte offset for the lane mask
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      cap_size <= 3'b000;
      cap_off  <= 2'b00;
    end else if (accept) begin
      cap_size <= hsize;
      cap_off  <= haddr[1:0];
    end
  end

  // Byte lanes touched by the captured write
  always_comb begin
    lane_mask = 4'b1111;
    case (cap_size)
      3'b000:  lane_mask = 4'b0001 << cap_off;
      3'b001:  lane_mask = cap_off[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  end

  // Commit write data into the addressed lanes at the end of the data phase
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_mask[b]) mem[cap_idx][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
  end
`else
  // Commit the full write word at the end of the data phase
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_write) begin
      mem[cap_idx] <= hwdata;
    end
  end
`endif

  assign hrdata = (state == ST_DATA && !cap_write) ? mem[cap_idx] : 32'h0;

endmodule

// File: doc/ahb_slave_mem.md
Name: ahb_slave_mem

Overview:
AHB slave (responder) with a small word-addressed register-file memory. It is the other end of the transfers issued by the master interface and the master stimulus modules. It decodes the address phase, inserts a configurable number of wait states, and commits writes or returns read data. Out-of-range or illegal accesses get a two-cycle ERROR response. The block sits behind the decoder/mux, one instance per slave select.

Parameters:
ADDR_W, 4, word-address bits; memory depth 2**ADDR_W words of 32 bits, byte range 0 .. 4*2**ADDR_W-1
WAIT_STATES, 1, hreadyout-low cycles inserted in every OKAY NONSEQ/SEQ data phase (0..7)

Ports:
hclk  input  1  bus clock, rising edge
hresetn  input  1  asynchronous active-low reset
hsel  input  1  slave select from decoder
haddr  input  32  transfer address
htrans  input  2  IDLE=00 BUSY=01 NONSEQ=10 SEQ=11
hwrite  input  1  1 = write, 0 = read
hsize  input  3  000 byte, 001 halfword, 010 word
hwdata  input  32  write data, data phase
hready  input  1  bus-level ready (previous transfer complete)
hreadyout  output  1  slave ready
hresp  output  2  OKAY=00, ERROR=01
hrdata  output  32  read data

Behaviour:
- Reset (async, hresetn low): state ST_IDLE; hreadyout=1; hresp=00; hrdata=0; all memory words 0; captured address/control cleared; any pending write is discarded.
- Address phase accepted on a rising edge with hsel & hready & htrans[1]. Capture word index haddr[ADDR_W+1:2], hwrite, hsize, haddr[1:0].
- Error condition at capture: any of haddr[31:ADDR_W+2] nonzero; hsize>010; misaligned (word with haddr[1:0]!=0; halfword with haddr[0]=1); hsize!=010 when the feature is off.
- States:
  - ST_IDLE: hreadyout=1, hresp=OKAY. On an accept: error -> ST_ERR1; else WAIT_STATES>0 -> ST_WAIT (counter loaded WAIT_STATES-1); else ST_DATA.
  - ST_WAIT: hreadyout=0, hresp=OKAY. Counter decrements; at 0 -> ST_DATA. New address phases are not accepted (hready is low).
  - ST_DATA: hreadyout=1, hresp=OKAY. Write: memory updated at the edge ending this cycle with hwdata (lane-masked when the feature is on). Read: hrdata = mem[captured index], combinational from the stored array. On the same edge, a new accept takes the ST_IDLE transitions (pipelined back-to-back); otherwise -> ST_IDLE.
  - ST_ERR1: hreadyout=0, hresp=ERROR -> ST_ERR2.
  - ST_ERR2: hreadyout=1, hresp=ERROR. No memory write. A new accept is processed as from ST_IDLE; otherwise -> ST_IDLE.
- hrdata is 0 outside read data phases.
- IDLE/BUSY with hsel: not captured; zero-wait OKAY (stays ST_IDLE, or continues the current data phase).
- hsel low, or hready low while in ST_IDLE: input ignored.
- Write followed by a read to the same word: the read returns the new data, because the commit precedes the read data phase. No forwarding is needed.
- Latency: read/write completes WAIT_STATES+1 cycles after address capture; error completes in 2 cycles.

Optional Feature:
AHB_SLV_BYTE_LANE_EN
- Defined: byte and halfword transfers are legal. Writes update only the addressed lanes: byte lane haddr[1:0]; halfword lanes {haddr[1],0} and {haddr[1],1}. Other lanes are preserved. Reads always return the full word.
- Undefined: any hsize!=010 gives an ERROR response. No lane-mask logic is present.

Test Plan:
- WAIT_STATES=1: NONSEQ write 0xA5A50001 to 0x08, then NONSEQ read 0x08 -> each data phase has hreadyout low 1 cycle then high; read hrdata=0xA5A50001, hresp=00.
- WAIT_STATES=0: back-to-back write 0x04=0x11, write 0x0C=0x22, read 0x04, read 0x0C -> hreadyout constantly 1; reads return 0x11 then 0x22.
- Read 0x100 (ADDR_W=4) -> cycle 1 hresp=01 hreadyout=0, cycle 2 hresp=01 hreadyout=1, memory unchanged.
- htrans=IDLE with hsel=1 at 0x00 -> hreadyout=1, hresp=00, no state change, no write.
- Assert hresetn low during ST_WAIT of a write to 0x08 -> immediately hreadyout=1, hresp=00, hrdata=0; later read of 0x08 returns 0.
- Feature on: word 0x08=0x11223344, byte write 0xAB to 0x09 (hwdata 0x0000AB00) -> read 0x08 = 0x1122AB44. Feature off: same byte write -> 2-cycle ERROR, word unchanged.
